// File: rtl/prt_dp_msg_pkg.sv
// Shared definitions for the DP receive message path: arbiter state encoding
// and the message IDs agreed between the message sources and the PM sink.
package prt_dp_msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam logic [7:0] MSG_ID_CTL = 8'h10;
  localparam logic [7:0] MSG_ID_TRN = 8'h11;
  localparam logic [7:0] MSG_ID_MSA = 8'h12;
  localparam logic [7:0] MSG_ID_VID = 8'h13;

  // Index reached by stepping forward from the last grant, wrapping modulo n.
  function automatic int unsigned rr_next(input int unsigned last, input int unsigned step,
                                          input int unsigned n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/prt_dp_lib_rr_sel.sv
// Combinational round-robin selector: returns the first set request found
// when searching upward from the index after the last grant.
module prt_dp_lib_rr_sel #(
  parameter int  P_REQ = 4,
  localparam int LP_W  = $clog2(P_REQ)
) (
  input  logic [P_REQ-1:0] i_req,
  input  logic [LP_W-1:0]  i_last,
  output logic [LP_W-1:0]  o_gnt,
  output logic             o_found
);
  import prt_dp_msg_pkg::*;

  logic [LP_W-1:0] w_gnt;
  logic            w_found;
  logic [LP_W-1:0] w_idx;
  logic            w_hit;

  // Rotating priority search; the first hit locks the result.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int i = 1; i <= P_REQ; i++) begin
      w_idx   = LP_W'(rr_next(32'(i_last), i, P_REQ));
      w_hit   = !w_found && i_req[w_idx];
      w_gnt   = w_hit ? w_idx : w_gnt;
      w_found = w_found | w_hit;
    end
  end

  assign o_gnt   = w_gnt;
  assign o_found = w_found;

endmodule

// File: rtl/prt_dprx_msg_arb.sv
// Message-locked round-robin arbiter sharing the PM message return path
// between link-domain sources; stalled or malformed messages are aborted.
module prt_dprx_msg_arb #(
  parameter int  P_REQ     = 4,
  parameter int  P_MSG_DAT = 16,
  parameter int  P_TIMEOUT = 255,
  localparam int LP_GW     = $clog2(P_REQ)
) (
  input  logic                       CLK_IN,
  input  logic                       RST_IN,
  input  logic [P_REQ-1:0]           REQ_VLD_IN,
  input  logic [P_REQ-1:0]           REQ_SOM_IN,
  input  logic [P_REQ-1:0]           REQ_EOM_IN,
  input  logic [P_REQ*P_MSG_DAT-1:0] REQ_DAT_IN,
  output logic [P_REQ-1:0]           REQ_RDY_OUT,
  output logic                       MSG_SOM_OUT,
  output logic                       MSG_EOM_OUT,
  output logic [P_MSG_DAT-1:0]       MSG_DAT_OUT,
  output logic                       MSG_VLD_OUT,
  output logic [LP_GW-1:0]           STA_GNT_OUT,
  output logic                       ERR_OUT
);
  import prt_dp_msg_pkg::*;

  localparam logic [15:0]      LP_TO_LAST  = 16'(P_TIMEOUT - 1);
  localparam logic [LP_GW-1:0] LP_LAST_RST = LP_GW'(P_REQ - 1);

  arb_state_e           r_state;
  logic [LP_GW-1:0]     r_gnt;
  logic [LP_GW-1:0]     r_last;
  logic [15:0]          r_cnt;
  logic                 r_first;
  logic                 r_msg_vld;
  logic                 r_msg_som;
  logic                 r_msg_eom;
  logic [P_MSG_DAT-1:0] r_msg_dat;
  logic                 r_err;

  logic [P_REQ-1:0]     w_cand;
  logic [P_REQ-1:0]     w_stray;
  logic [LP_GW-1:0]     w_win_idx;
  logic                 w_win_found;
  logic [LP_GW-1:0]     w_stray_idx;
  logic                 w_stray_found;
  logic [P_REQ-1:0]     w_rdy;
  logic                 w_acc;
  logic                 w_acc_som;
  logic                 w_acc_eom;
  logic [P_MSG_DAT-1:0] w_acc_dat;

  assign w_cand  = REQ_VLD_IN & REQ_SOM_IN;
  assign w_stray = REQ_VLD_IN & ~REQ_SOM_IN;

  prt_dp_lib_rr_sel #(.P_REQ(P_REQ)) u_rr_sel (
    .i_req   (w_cand),
    .i_last  (r_last),
    .o_gnt   (w_win_idx),
    .o_found (w_win_found)
  );

  // Lowest-index stray beat: scanning downward leaves the lowest hit last.
  always_comb begin
    w_stray_idx   = '0;
    w_stray_found = 1'b0;
    for (int i = P_REQ - 1; i >= 0; i--) begin
      w_stray_idx   = w_stray[i] ? LP_GW'(i) : w_stray_idx;
      w_stray_found = w_stray_found | w_stray[i];
    end
  end

  assign w_acc     = (r_state == ST_XFER) && REQ_VLD_IN[r_gnt];
  assign w_acc_som = REQ_SOM_IN[r_gnt];
  assign w_acc_eom = REQ_EOM_IN[r_gnt];
  assign w_acc_dat = REQ_DAT_IN[32'(r_gnt) * P_MSG_DAT +: P_MSG_DAT];

  // Ready: granted source in XFER, otherwise a single stray drain when no SOM is pending.
  always_comb begin
    w_rdy = '0;
    if (RST_IN) begin
      w_rdy = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_win_found && w_stray_found) begin
            w_rdy[w_stray_idx] = 1'b1;
          end else begin
            w_rdy = '0;
          end
        end
        ST_XFER: w_rdy[r_gnt] = 1'b1;
        default: w_rdy = '0;
      endcase
    end
  end

  // Arbitration state, timeout tracking and registered PM-side outputs.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_last    <= LP_LAST_RST;
      r_cnt     <= 16'd0;
      r_first   <= 1'b0;
      r_msg_vld <= 1'b0;
      r_msg_som <= 1'b0;
      r_msg_eom <= 1'b0;
      r_msg_dat <= '0;
      r_err     <= 1'b0;
    end else begin
      r_msg_vld <= 1'b0;
      r_msg_som <= 1'b0;
      r_msg_eom <= 1'b0;
      r_msg_dat <= '0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_gnt   <= w_win_idx;
            r_cnt   <= 16'd0;
            r_first <= 1'b1;
            r_state <= ST_XFER;
          end else begin
            r_err <= w_stray_found;
          end
        end
        ST_XFER: begin
          if (w_acc) begin
            r_msg_vld <= 1'b1;
            r_msg_som <= w_acc_som;
            r_msg_dat <= w_acc_dat;
            r_first   <= 1'b0;
            r_cnt     <= 16'd0;
            // A restart inside a message closes the current one; last grant is kept.
            if (w_acc_som && !r_first) begin
              r_msg_eom <= 1'b1;
              r_err     <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (w_acc_eom) begin
              r_msg_eom <= 1'b1;
              r_last    <= r_gnt;
              r_state   <= ST_IDLE;
            end else begin
              r_msg_eom <= 1'b0;
            end
          end else if (r_cnt == LP_TO_LAST) begin
            r_msg_vld <= 1'b1;
            r_msg_eom <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= ST_ABORT;
          end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_ABORT: begin
          r_last  <= r_gnt;
          r_cnt   <= 16'd0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign REQ_RDY_OUT = w_rdy;
  assign MSG_VLD_OUT = r_msg_vld;
  assign MSG_SOM_OUT = r_msg_som;
  assign MSG_EOM_OUT = r_msg_eom;
  assign MSG_DAT_OUT = r_msg_dat;
  assign STA_GNT_OUT = r_gnt;
  assign ERR_OUT     = r_err;

endmodule

// File: tb/tb_prt_dprx_msg_arb.sv
// Scoreboard bench for prt_dprx_msg_arb: sources push expected PM beats on
// acceptance, a negedge monitor pops and compares every beat the DUT emits.
module tb_prt_dprx_msg_arb;

  localparam int P_REQ = 4;
  localparam int P_DAT = 16;
  localparam int P_TO  = 8;

  typedef struct packed {
    logic        som;
    logic        eom;
    logic [15:0] dat;
    logic [1:0]  gnt;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        req_vld_a [P_REQ];
  logic        req_som_a [P_REQ];
  logic        req_eom_a [P_REQ];
  logic [15:0] req_dat_a [P_REQ];

  logic [P_REQ-1:0]       req_vld;
  logic [P_REQ-1:0]       req_som;
  logic [P_REQ-1:0]       req_eom;
  logic [P_REQ*P_DAT-1:0] req_dat;
  logic [P_REQ-1:0]       rdy;
  logic                   msg_som;
  logic                   msg_eom;
  logic [P_DAT-1:0]       msg_dat;
  logic                   msg_vld;
  logic [1:0]             sta_gnt;
  logic                   err;

  beat_t sb [$];
  int    gnt_log [$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    som_cyc = 0;
  int    err_beat_cyc = 0;
  int    stray_err = 0;
  beat_t act_b;
  beat_t exp_b;

  always_comb begin
    req_vld = '0;
    req_som = '0;
    req_eom = '0;
    req_dat = '0;
    for (int i = 0; i < P_REQ; i++) begin
      req_vld[i] = req_vld_a[i];
      req_som[i] = req_som_a[i];
      req_eom[i] = req_eom_a[i];
      req_dat[i*P_DAT +: P_DAT] = req_dat_a[i];
    end
  end

  prt_dprx_msg_arb #(.P_REQ(P_REQ), .P_MSG_DAT(P_DAT), .P_TIMEOUT(P_TO)) dut (
    .CLK_IN      (clk),
    .RST_IN      (rst),
    .REQ_VLD_IN  (req_vld),
    .REQ_SOM_IN  (req_som),
    .REQ_EOM_IN  (req_eom),
    .REQ_DAT_IN  (req_dat),
    .REQ_RDY_OUT (rdy),
    .MSG_SOM_OUT (msg_som),
    .MSG_EOM_OUT (msg_eom),
    .MSG_DAT_OUT (msg_dat),
    .MSG_VLD_OUT (msg_vld),
    .STA_GNT_OUT (sta_gnt),
    .ERR_OUT     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: compare each emitted beat against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (msg_vld) begin
        act_b = {msg_som, msg_eom, msg_dat, sta_gnt, err};
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_beat", 32'(act_b), 32'h0);
        end else begin
          exp_b = sb.pop_front();
          check(act_b == exp_b, "beat", 32'(act_b), 32'(exp_b));
        end
        if (msg_som) begin
          gnt_log.push_back(int'(sta_gnt));
          som_cyc = cyc;
        end
        if (err) err_beat_cyc = cyc;
      end else begin
        check({msg_som, msg_eom, msg_dat} == 18'd0, "idle_zero",
              32'({msg_som, msg_eom, msg_dat}), 32'h0);
        if (err) stray_err++;
      end
    end
  end

  task automatic send_beat(input int r, input logic som, input logic eom, input logic [15:0] dat,
                           input logic exp_eom, input logic exp_err);
    bit got;
    got = 1'b0;
    req_vld_a[r] = 1'b1;
    req_som_a[r] = som;
    req_eom_a[r] = eom;
    req_dat_a[r] = dat;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (rdy[r]) got = 1'b1;
    end
    check(got, "rdy_wait", 32'(got), 32'h1);
    if (got) begin
      sb.push_back({som, exp_eom, dat, 2'(r), exp_err});
      @(posedge clk);
      #1;
    end
    req_vld_a[r] = 1'b0;
    req_som_a[r] = 1'b0;
    req_eom_a[r] = 1'b0;
  endtask

  task automatic send_msg(input int r, input int n, input logic [15:0] base);
    for (int b = 0; b < n; b++) begin
      send_beat(r, b == 0, b == n - 1, base + 16'(b), b == n - 1, 1'b0);
    end
  endtask

  function automatic int log_at(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : -1;
  endfunction

  initial begin
    int nb;
    int t0;
    int t_som;
    int exp_fair [4] = '{0, 2, 0, 2};
    for (int i = 0; i < P_REQ; i++) begin
      req_vld_a[i] = 1'b0;
      req_som_a[i] = 1'b0;
      req_eom_a[i] = 1'b0;
      req_dat_a[i] = 16'h0;
    end
    #1;
    check({msg_vld, msg_som, msg_eom, msg_dat, sta_gnt, err, rdy} == 25'd0, "reset_outputs",
          32'({msg_vld, msg_som, msg_eom, msg_dat, sta_gnt, err, rdy}), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fairness: sources 0 and 2 keep offering 2-beat messages.
    @(posedge clk); #1;
    nb = gnt_log.size();
    fork
      begin send_msg(0, 2, 16'h0A00); send_msg(0, 2, 16'h0A10); end
      begin send_msg(2, 2, 16'h2A00); send_msg(2, 2, 16'h2A10); end
    join
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check(log_at(nb + i) == exp_fair[i], "fair_gnt",
                                      32'(log_at(nb + i)), 32'(exp_fair[i]));

    // Single source: 3-beat message from source 1, first output 2 cycles after VLD.
    @(posedge clk); #1;
    t0 = cyc;
    nb = gnt_log.size();
    send_beat(1, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    send_beat(1, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0);
    send_beat(1, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check(som_cyc - t0 == 2, "single_latency", 32'(som_cyc - t0), 32'd2);
    check(log_at(nb) == 1, "single_gnt", 32'(log_at(nb)), 32'd1);

    // Stray beat while idle: drained for one cycle, ERR only.
    @(posedge clk); #1;
    req_vld_a[0] = 1'b1;
    req_som_a[0] = 1'b0;
    req_dat_a[0] = 16'hDEAD;
    @(negedge clk);
    check(rdy == 4'b0001, "stray_rdy", 32'(rdy), 32'h1);
    @(posedge clk); #1;
    req_vld_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    check(stray_err == 1, "stray_err", 32'(stray_err), 32'd1);

    // Timeout: source 3 stalls after SOM; abort beat 8 cycles later, then source 0.
    send_beat(3, 1'b1, 1'b0, 16'h3A3A, 1'b0, 1'b0);
    sb.push_back({1'b0, 1'b1, 16'h0000, 2'd3, 1'b1});
    @(negedge clk); #1;
    t_som = som_cyc;
    send_beat(0, 1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check(err_beat_cyc - t_som == P_TO, "abort_delay", 32'(err_beat_cyc - t_som), 32'(P_TO));

    // Mid-message SOM: third beat closes the message, then source 1 is re-granted.
    send_beat(1, 1'b1, 1'b0, 16'hA001, 1'b0, 1'b0);
    send_beat(1, 1'b0, 1'b0, 16'hA002, 1'b0, 1'b0);
    send_beat(1, 1'b1, 1'b0, 16'hA003, 1'b1, 1'b1);
    send_msg(1, 3, 16'hB001);
    repeat (2) @(negedge clk);

    // Async reset mid-message.
    send_beat(1, 1'b1, 1'b0, 16'hC001, 1'b0, 1'b0);
    req_vld_a[1] = 1'b1;
    req_som_a[1] = 1'b0;
    req_dat_a[1] = 16'hC002;
    sb.push_back({1'b0, 1'b0, 16'hC002, 2'd1, 1'b0});
    @(posedge clk);
    #6;
    rst = 1'b1;
    req_vld_a[1] = 1'b0;
    #1;
    check({msg_vld, msg_som, msg_eom, msg_dat, sta_gnt, err, rdy} == 25'd0, "async_reset",
          32'({msg_vld, msg_som, msg_eom, msg_dat, sta_gnt, err, rdy}), 32'h0);
    nb = gnt_log.size();
    fork
      send_beat(0, 1'b1, 1'b1, 16'h0C0C, 1'b1, 1'b0);
      send_beat(2, 1'b1, 1'b1, 16'h2C2C, 1'b1, 1'b0);
      begin repeat (2) @(negedge clk); rst = 1'b0; end
    join
    repeat (3) @(negedge clk);
    check(log_at(nb) == 0, "post_reset_first", 32'(log_at(nb)), 32'd0);
    check(log_at(nb + 1) == 2, "post_reset_second", 32'(log_at(nb + 1)), 32'd2);
    check(sb.size() == 0, "sb_empty", 32'(sb.size()), 32'd0);
    check(stray_err == 1, "stray_err_total", 32'(stray_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
